// File: rtl/button_event_decoder.sv
// Push-button input conditioner for the expansion header.
// Per button: two-flop synchroniser, debounce counter, debounced level and
// one-cycle press/release pulses. Press pulses are priority-encoded into a
// single-entry KeyCode/KeyValid register with KeyAck handshake and a sticky
// Overrun flag.
module button_event_decoder #(
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter int unsigned CODE_WIDTH      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NUM_BUTTONS-1:0] Switch,
  output logic [NUM_BUTTONS-1:0] Pressed,
  output logic [NUM_BUTTONS-1:0] PressPulse,
  output logic [NUM_BUTTONS-1:0] ReleasePulse,
  output logic [CODE_WIDTH-1:0]  KeyCode,
  output logic                   KeyValid,
  input  logic                   KeyAck,
  output logic                   Overrun
);

  // Terminal count: a level change is accepted on the edge that sees the
  // counter at this value with the new level still present.
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchroniser and debounce state. Switch is active-low, so the idle
  // (released) raw level is 1.
  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;
  logic [NUM_BUTTONS-1:0] stable_q;
  logic [NUM_BUTTONS-1:0] stable_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];

  // Edge pulses, registered alongside stable_q.
  logic [NUM_BUTTONS-1:0] press_pulse_q;
  logic [NUM_BUTTONS-1:0] press_pulse_d;
  logic [NUM_BUTTONS-1:0] release_pulse_q;
  logic [NUM_BUTTONS-1:0] release_pulse_d;

  // Event holding register.
  logic [CODE_WIDTH-1:0]  key_code_q;
  logic [CODE_WIDTH-1:0]  key_code_d;
  logic                   key_valid_q;
  logic                   key_valid_d;
  logic                   overrun_q;
  logic                   overrun_d;

  // Press-event decode.
  logic                   new_event;
  logic                   multi_event;
  logic [CODE_WIDTH-1:0]  event_code;

  // Per-bit debounce: count consecutive cycles of disagreement, accept the
  // new level at the terminal count, clear the counter on any agreement.
  always_comb begin
    stable_d        = stable_q;
    press_pulse_d   = '0;
    release_pulse_d = '0;
    for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i]        = sync2_q[i];
          // Raw level going low means the button was pressed.
          press_pulse_d[i]   = ~sync2_q[i];
          release_pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index priority encode of the registered press pulses.
  always_comb begin
    event_code = '0;
    for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
      if (press_pulse_q[i]) begin
        event_code = CODE_WIDTH'(i);
      end
    end
    new_event   = |press_pulse_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_event = |(press_pulse_q & (press_pulse_q - NUM_BUTTONS'(1)));
  end

  // Event register next state: load on a new press when free or being
  // acknowledged, otherwise flag the drop; a bare ack empties the register.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (new_event) begin
      if (!key_valid_q || KeyAck) begin
        key_code_d  = event_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (multi_event) begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && KeyAck) begin
      key_valid_d = 1'b0;
    end
  end

  // State update with synchronous active-high reset taking priority.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q         <= '1;
      sync2_q         <= '1;
      stable_q        <= '1;
      for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
        cnt_q[i] <= '0;
      end
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      key_code_q      <= '0;
      key_valid_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      sync1_q         <= Switch;
      sync2_q         <= sync1_q;
      stable_q        <= stable_d;
      for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      key_code_q      <= key_code_d;
      key_valid_q     <= key_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Pressed      = ~stable_q;
    PressPulse   = press_pulse_q;
    ReleasePulse = release_pulse_q;
    KeyCode      = key_code_q;
    KeyValid     = key_valid_q;
    Overrun      = overrun_q;
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with a short debounce window.
// Directed scenarios use constant expectations; a randomized run is checked
// cycle by cycle against a sliding-window reference model.
module tb_button_event_decoder;

  localparam int NB   = 8;
  localparam int CW   = 3;
  localparam int DB   = 4;
  localparam int CNTW = 20;

  logic          Clk    = 1'b0;
  logic          Rst    = 1'b1;
  logic [NB-1:0] Switch = '1;
  logic          KeyAck = 1'b0;
  logic [NB-1:0] Pressed;
  logic [NB-1:0] PressPulse;
  logic [NB-1:0] ReleasePulse;
  logic [CW-1:0] KeyCode;
  logic          KeyValid;
  logic          Overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [NB-1:0] m_stable = '1;
  logic [NB-1:0] m_press  = '0;
  logic [NB-1:0] m_rel    = '0;
  logic [CW-1:0] m_code   = '0;
  logic          m_valid  = 1'b0;
  logic          m_ovr    = 1'b0;
  // Switch values sampled at each edge, newest first.
  logic [NB-1:0] hist[$];

  always #5 Clk = ~Clk;

  button_event_decoder #(
    .NUM_BUTTONS    (NB),
    .CODE_WIDTH     (CW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CNTW)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Switch      (Switch),
    .Pressed     (Pressed),
    .PressPulse  (PressPulse),
    .ReleasePulse(ReleasePulse),
    .KeyCode     (KeyCode),
    .KeyValid    (KeyValid),
    .KeyAck      (KeyAck),
    .Overrun     (Overrun)
  );

  // Model of one clock edge. A level is accepted at edge t when the raw
  // samples taken at edges t-2 .. t-DB-1 (two-flop delay) all differ from the
  // currently accepted level.
  task automatic model_edge();
    int lo;
    bit accept;
    if (Rst) begin
      hist.delete();
      for (int k = 0; k < DB + 2; k++) hist.push_front('1);
      m_stable = '1;
      m_press  = '0;
      m_rel    = '0;
      m_code   = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      if (m_press != '0) begin
        lo = 0;
        for (int i = NB - 1; i >= 0; i--) if (m_press[i]) lo = i;
        if (!m_valid || KeyAck) begin
          m_code  = CW'(lo);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        if ($countones(m_press) > 1) m_ovr = 1'b1;
      end else if (m_valid && KeyAck) begin
        m_valid = 1'b0;
      end
      hist.push_front(Switch);
      if (hist.size() > DB + 2) void'(hist.pop_back());
      for (int i = 0; i < NB; i++) begin
        accept = 1'b1;
        for (int m = 0; m < DB; m++) begin
          if (hist[2 + m][i] == m_stable[i]) accept = 1'b0;
        end
        m_press[i] = accept && m_stable[i];
        m_rel[i]   = accept && !m_stable[i];
        if (accept) m_stable[i] = ~m_stable[i];
      end
    end
  endtask

  // One clock: model follows the edge, outputs settle before sampling.
  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    Rst    = 1'b1;
    Switch = '1;
    KeyAck = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win even with every button held down.
    Rst    = 1'b1;
    Switch = '0;
    KeyAck = 1'b1;
    tick();
    tick();
    n_tests++;
    if (Pressed !== '0) begin
      n_fail++; $display("FAIL reset_pressed got %h want 00", Pressed);
    end
    n_tests++;
    if (PressPulse !== '0 || ReleasePulse !== '0) begin
      n_fail++; $display("FAIL reset_pulses got %h/%h want 00/00", PressPulse, ReleasePulse);
    end
    n_tests++;
    if (KeyCode !== '0 || KeyValid !== 1'b0 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_event got code=%0d valid=%b ovr=%b want 0/0/0",
                         KeyCode, KeyValid, Overrun);
    end
    Switch = '1;
    KeyAck = 1'b0;
    Rst    = 1'b0;
  endtask

  task automatic test_single_press();
    do_reset();
    Switch[3] = 1'b0;
    repeat (DB + 1) tick();
    n_tests++;
    if (Pressed !== 8'h00) begin
      n_fail++; $display("FAIL press_too_early got %h want 00", Pressed);
    end
    tick();
    n_tests++;
    if (Pressed !== 8'h08 || PressPulse !== 8'h08) begin
      n_fail++; $display("FAIL press_latency got %h/%h want 08/08", Pressed, PressPulse);
    end
    tick();
    n_tests++;
    if (PressPulse !== 8'h00 || Pressed !== 8'h08) begin
      n_fail++; $display("FAIL press_pulse_width got %h/%h want 00/08", PressPulse, Pressed);
    end
    n_tests++;
    if (KeyValid !== 1'b1 || KeyCode !== 3'd3 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL press_event got code=%0d valid=%b ovr=%b want 3/1/0",
                         KeyCode, KeyValid, Overrun);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    bit bad;
    do_reset();
    // Too short a low: never accepted.
    Switch[0] = 1'b0;
    repeat (DB - 1) tick();
    Switch[0] = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 2 * DB + 4; c++) begin
      tick();
      if (Pressed !== '0 || PressPulse !== '0 || KeyValid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL glitch_rejected got pressed=%h pulse=%h valid=%b want 00/00/0",
                         Pressed, PressPulse, KeyValid);
    end
    // Long enough low: accepted.
    Switch[0] = 1'b0;
    repeat (DB + 1) tick();
    Switch[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (PressPulse === 8'h01) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL glitch_long_accept got pulse=%h want 01 within 10 cycles", PressPulse);
    end
    tick();
    n_tests++;
    if (KeyValid !== 1'b1 || KeyCode !== 3'd0) begin
      n_fail++; $display("FAIL glitch_long_event got code=%0d valid=%b want 0/1", KeyCode, KeyValid);
    end
    repeat (3 * DB) tick();
  endtask

  task automatic test_multi_press();
    do_reset();
    Switch = ~8'h24;
    repeat (DB + 2) tick();
    n_tests++;
    if (PressPulse !== 8'h24) begin
      n_fail++; $display("FAIL multi_pulse got %h want 24", PressPulse);
    end
    tick();
    n_tests++;
    if (KeyCode !== 3'd2 || KeyValid !== 1'b1 || Overrun !== 1'b1 || PressPulse !== 8'h00) begin
      n_fail++; $display("FAIL multi_event got code=%0d valid=%b ovr=%b pulse=%h want 2/1/1/00",
                         KeyCode, KeyValid, Overrun, PressPulse);
    end
  endtask

  task automatic test_pending_drop();
    do_reset();
    Switch[3] = 1'b0;
    repeat (DB + 3) tick();
    n_tests++;
    if (KeyValid !== 1'b1 || KeyCode !== 3'd3 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL pend_first got code=%0d valid=%b ovr=%b want 3/1/0",
                         KeyCode, KeyValid, Overrun);
    end
    Switch[7] = 1'b0;
    repeat (DB + 2) tick();
    n_tests++;
    if (PressPulse !== 8'h80) begin
      n_fail++; $display("FAIL pend_pulse got %h want 80", PressPulse);
    end
    tick();
    n_tests++;
    if (KeyCode !== 3'd3 || KeyValid !== 1'b1 || Overrun !== 1'b1) begin
      n_fail++; $display("FAIL pend_drop got code=%0d valid=%b ovr=%b want 3/1/1",
                         KeyCode, KeyValid, Overrun);
    end
  endtask

  task automatic test_ack_collide();
    do_reset();
    Switch[3] = 1'b0;
    repeat (DB + 3) tick();
    Switch[6] = 1'b0;
    repeat (DB + 2) tick();
    n_tests++;
    if (PressPulse !== 8'h40 || KeyValid !== 1'b1) begin
      n_fail++; $display("FAIL collide_setup got pulse=%h valid=%b want 40/1", PressPulse, KeyValid);
    end
    KeyAck = 1'b1;
    tick();
    KeyAck = 1'b0;
    n_tests++;
    if (KeyCode !== 3'd6 || KeyValid !== 1'b1 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL collide_load got code=%0d valid=%b ovr=%b want 6/1/0",
                         KeyCode, KeyValid, Overrun);
    end
    KeyAck = 1'b1;
    tick();
    KeyAck = 1'b0;
    n_tests++;
    if (KeyValid !== 1'b0 || KeyCode !== 3'd6) begin
      n_fail++; $display("FAIL ack_clear got code=%0d valid=%b want 6/0", KeyCode, KeyValid);
    end
    // Ack with nothing pending is ignored.
    KeyAck = 1'b1;
    tick();
    KeyAck = 1'b0;
    n_tests++;
    if (KeyValid !== 1'b0 || KeyCode !== 3'd6 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL ack_idle got code=%0d valid=%b ovr=%b want 6/0/0",
                         KeyCode, KeyValid, Overrun);
    end
  endtask

  // Runs on from the state left by test_ack_collide (buttons 3 and 6 held).
  task automatic test_release();
    Switch[3] = 1'b1;
    repeat (DB + 1) tick();
    n_tests++;
    if (ReleasePulse !== 8'h00 || Pressed !== 8'h48) begin
      n_fail++; $display("FAIL release_early got rel=%h pressed=%h want 00/48", ReleasePulse, Pressed);
    end
    tick();
    n_tests++;
    if (ReleasePulse !== 8'h08 || Pressed !== 8'h40 || PressPulse !== 8'h00) begin
      n_fail++; $display("FAIL release_pulse got rel=%h pressed=%h press=%h want 08/40/00",
                         ReleasePulse, Pressed, PressPulse);
    end
    tick();
    n_tests++;
    if (ReleasePulse !== 8'h00 || KeyValid !== 1'b0 || KeyCode !== 3'd6) begin
      n_fail++; $display("FAIL release_after got rel=%h code=%0d valid=%b want 00/6/0",
                         ReleasePulse, KeyCode, KeyValid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Switch[3] = 1'b0;
    repeat (DB + 3) tick();
    Switch[1] = 1'b0;
    repeat (2) tick();
    Rst = 1'b1;
    tick();
    n_tests++;
    if (Pressed !== '0 || PressPulse !== '0 || ReleasePulse !== '0 || KeyCode !== '0 ||
        KeyValid !== 1'b0 || Overrun !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got pr=%h pp=%h rp=%h code=%0d valid=%b ovr=%b want all 0",
                         Pressed, PressPulse, ReleasePulse, KeyCode, KeyValid, Overrun);
    end
    Rst = 1'b0;
    repeat (DB + 1) tick();
    n_tests++;
    if (Pressed !== 8'h00) begin
      n_fail++; $display("FAIL midrst_early got %h want 00", Pressed);
    end
    tick();
    n_tests++;
    if (Pressed !== 8'h0A || PressPulse !== 8'h0A) begin
      n_fail++; $display("FAIL midrst_redebounce got %h/%h want 0a/0a", Pressed, PressPulse);
    end
    tick();
    n_tests++;
    if (KeyCode !== 3'd1 || KeyValid !== 1'b1 || Overrun !== 1'b1) begin
      n_fail++; $display("FAIL midrst_event got code=%0d valid=%b ovr=%b want 1/1/1",
                         KeyCode, KeyValid, Overrun);
    end
  endtask

  task automatic test_random();
    int idx;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NB - 1);
        Switch[idx] = ~Switch[idx];
      end
      KeyAck = ($urandom_range(0, 3) == 0);
      Rst    = ($urandom_range(0, 599) == 0);
      tick();
      n_tests++;
      if ({Pressed, PressPulse, ReleasePulse, KeyCode, KeyValid, Overrun} !==
          {~m_stable, m_press, m_rel, m_code, m_valid, m_ovr}) begin
        n_fail++;
        $display("FAIL random_c%0d got pr=%h pp=%h rp=%h code=%0d v=%b o=%b want pr=%h pp=%h rp=%h code=%0d v=%b o=%b",
                 c, Pressed, PressPulse, ReleasePulse, KeyCode, KeyValid, Overrun,
                 ~m_stable, m_press, m_rel, m_code, m_valid, m_ovr);
      end
    end
    Rst    = 1'b0;
    KeyAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_press();
    test_pending_drop();
    test_ack_collide();
    test_release();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
